// File: rtl/game_link_pkg.sv
// Shared game-link message constants, types and byte builders; pure definitions, no timing.
// GAME_UART_TX_PARITY_EN selects 8E1 (11-bit frame) instead of 8N1 (10-bit frame).
package game_link_pkg;

   localparam logic [7:0] MSG_START_BYTE = 8'hA5;
   localparam logic [7:0] MSG_SCORE_HDR  = 8'h5C;

   typedef enum logic [1:0] {
      MSG_NONE  = 2'd0,
      MSG_START = 2'd1,
      MSG_SCORE = 2'd2
   } msg_t;

`ifdef GAME_UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   function automatic logic [1:0] msg_len(input msg_t m);
      logic [1:0] n;
      case (m)
         MSG_START: n = 2'd1;
         MSG_SCORE: n = 2'd3;
         default:   n = 2'd0;
      endcase
      return n;
   endfunction

   // SCORE checksum is header XOR payload
   function automatic logic [7:0] msg_byte(input msg_t m, input logic [1:0] idx,
                                           input logic [6:0] s);
      logic [7:0] b;
      b = MSG_START_BYTE;
      if (m == MSG_SCORE) begin
         case (idx)
            2'd0:    b = MSG_SCORE_HDR;
            2'd1:    b = {1'b0, s};
            default: b = MSG_SCORE_HDR ^ {1'b0, s};
         endcase
      end
      return b;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Byte serializer (start, d0..d7, [even parity if GAME_UART_TX_PARITY_EN], stop); tx from a flop.
// Accepts a byte the edge after valid&ready; ready rises in the last stop cycle so frames chain back-to-back.
module uart_tx_byte
   import game_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = 651
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       tx,
   output logic       done
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(FRAME_BITS);
   localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

   logic                  active;
   logic [CW-1:0]         clk_cnt;
   logic [BW-1:0]         bit_idx;
   logic [FRAME_BITS-2:0] sh;
   logic [FRAME_BITS-2:0] frame_rest;

`ifdef GAME_UART_TX_PARITY_EN
   assign frame_rest = {1'b1, ^data, data};
`else
   assign frame_rest = {1'b1, data};
`endif

   assign done  = active && (clk_cnt == CNT_MAX) && (bit_idx == BIT_LAST);
   assign ready = !active || done;

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         active  <= 1'b0;
         clk_cnt <= '0;
         bit_idx <= '0;
         sh      <= '1;
         tx      <= 1'b1;
      end else if (valid && ready) begin
         active  <= 1'b1;
         clk_cnt <= '0;
         bit_idx <= '0;
         sh      <= frame_rest;
         tx      <= 1'b0;
      end else if (active) begin
         if (clk_cnt == CNT_MAX) begin
            clk_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
               active <= 1'b0;
               tx     <= 1'b1;
            end else begin
               bit_idx <= bit_idx + 1'b1;
               tx      <= sh[0];
               sh      <= {1'b1, sh[FRAME_BITS-2:1]};
            end
         end else begin
            clk_cnt <= clk_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/game_uart_tx.sv
// Game-link UART transmitter: queues START/SCORE requests and sends them as byte frames.
// Start bit 2 edges after an idle request; requests never stall, repeats of a pending type merge.
module game_uart_tx
   import game_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = 651,
   parameter int MSG_GAP_BITS = 1
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic       send_start,
   input  logic       send_score,
   input  logic [6:0] score,
   output logic       tx,
   output logic       busy,
   output logic       msg_done
);

   // gap counted from the msg_done cycle, so the next start bit lands GAP_CYC+1 later
   localparam int GAP_CYC = (MSG_GAP_BITS * CLKS_PER_BIT < 1) ? 1 : MSG_GAP_BITS * CLKS_PER_BIT;
   localparam int GW      = $clog2(GAP_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

   state_t     state, state_nxt;
   msg_t       msg, load_sel;
   logic [1:0] byte_idx;
   logic [6:0] score_q, score_tx;
   logic       start_pend, score_pend, any_pend;
   logic [GW-1:0] gap_cnt, gap_nxt;
   logic       load_go;
   logic       ser_valid, ser_ready, ser_done;
   logic [7:0] ser_data;

   assign any_pend = start_pend | score_pend;
   assign busy     = any_pend | (state != S_IDLE);

   always_comb begin
      state_nxt = state;
      gap_nxt   = gap_cnt;
      ser_valid = 1'b0;
      ser_data  = msg_byte(msg, byte_idx, score_tx);
      msg_done  = 1'b0;
      load_go   = 1'b0;
      load_sel  = start_pend ? MSG_START : MSG_SCORE;
      case (state)
         S_IDLE: load_go = any_pend;
         S_LOAD: begin
            ser_valid = 1'b1;
            if (ser_ready) state_nxt = S_SEND;
         end
         S_SEND: begin
            if (byte_idx != msg_len(msg)) begin
               ser_valid = 1'b1;
            end else if (ser_done) begin
               msg_done = 1'b1;
               if (GAP_CYC > 1) begin
                  state_nxt = S_GAP;
                  gap_nxt   = GW'(GAP_CYC - 2);
               end else begin
                  state_nxt = S_IDLE;
                  load_go   = any_pend;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt == '0) begin
               state_nxt = S_IDLE;
               load_go   = any_pend;
            end else begin
               gap_nxt = gap_cnt - 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (load_go) state_nxt = S_LOAD;
   end

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         gap_cnt    <= '0;
         msg        <= MSG_NONE;
         byte_idx   <= '0;
         score_q    <= '0;
         score_tx   <= '0;
         start_pend <= 1'b0;
         score_pend <= 1'b0;
      end else begin
         state   <= state_nxt;
         gap_cnt <= gap_nxt;
         if (send_score) score_q <= score;
         // a request in the same cycle as its own load re-arms the flag
         if (send_start)                              start_pend <= 1'b1;
         else if (load_go && load_sel == MSG_START)   start_pend <= 1'b0;
         if (send_score)                              score_pend <= 1'b1;
         else if (load_go && load_sel == MSG_SCORE)   score_pend <= 1'b0;
         if (load_go) begin
            msg      <= load_sel;
            byte_idx <= '0;
            score_tx <= score_q;
         end else if (ser_valid && ser_ready) begin
            byte_idx <= byte_idx + 1'b1;
         end
      end
   end

   uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
      .pclk  (pclk),
      .rst   (rst),
      .data  (ser_data),
      .valid (ser_valid),
      .ready (ser_ready),
      .tx    (tx),
      .done  (ser_done)
   );

endmodule

// File: doc/game_uart_tx.md
# game_uart_tx

Serial transmitter for the two-board game link. It sends the local player's "play clicked" event and final score to the opposite board over a single UART line. It is the sending end of the link whose receiving side produces `uart_start` and the opponent score in the top level. It sits in the `pclk` domain next to `click_ctl` and `score_counter`, packetizes requests into byte frames, and serializes them 8N1, LSB first.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 651: `pclk` cycles per bit (75 MHz / 115200 baud); minimum 2.
- `MSG_GAP_BITS`, default 1: idle bit-times inserted between consecutive messages.

Ports:
- `pclk`  in  1  system pixel clock; all logic on rising edge.
- `rst`  in  1  reset; **one clock; reset is asynchronous and active-low** (asserted when 0).
- `send_start`  in  1  one-cycle pulse: queue a START message.
- `send_score`  in  1  one-cycle pulse: queue a SCORE message carrying `score`.
- `score`  in  7  score value, sampled in the same cycle as `send_score`.
- `tx`  out  1  UART serial output; idle high.
- `busy`  out  1  high while any message is pending or being sent.
- `msg_done`  out  1  one-cycle pulse when the final stop bit of a message completes.

## Operation

- Messages:
  - START is 1 byte: `0xA5`.
  - SCORE is 3 bytes: `0x5C`, `{1'b0,score}`, then checksum `0x5C ^ {1'b0,score}`.
- Request capture: pulses set `start_pend` or `score_pend`.
  - `score` is latched into `score_q` on `send_score`.
  - A repeated request of a type that is already pending merges into it. For SCORE, `score_q` is updated to the newest value.
  - A request arriving during transmission of the same type is pended. That message is resent after the current one finishes.
- Arbitration: START has priority over SCORE. When both pulse in the same cycle, START is sent first, then SCORE.
- Sequencer FSM:
  - IDLE: wait for a pending flag.
  - LOAD: select the message, clear its pending flag, and freeze the payload (`score_q` is copied to `score_tx`).
  - SEND: hand bytes to the serializer in order.
  - GAP: idle for `MSG_GAP_BITS × CLKS_PER_BIT` cycles, then return to IDLE.
- Bytes inside a message go back-to-back: the next start bit follows the previous stop bit with no idle cycles.
- Serializer frame: start (0), d0..d7, [parity], stop (1). Each bit lasts exactly `CLKS_PER_BIT` cycles.
- `busy` is `start_pend | score_pend | (FSM != IDLE)`.
- Reset mid-operation: `tx` returns high immediately (asynchronously), pending flags clear, and the FSM goes to IDLE. No partial frame resumes.
- Reset values: `tx`=1, `busy`=0, `msg_done`=0, `score_q`=0, FSM=IDLE.

## Timing

- Latency: a request sampled at rising edge N while idle produces the start bit (`tx`=0) from edge N+2.
- Message duration: START is `10×CLKS_PER_BIT` cycles (11× with parity). SCORE is 3× that.
- `msg_done` asserts for one cycle at the end of the final stop bit. GAP begins in the same cycle.
- Earliest next start bit after `msg_done`: `MSG_GAP_BITS×CLKS_PER_BIT + 1` cycles later.
- `tx` is driven directly from a flop, with no combinational path to the pin.

## Configuration

- `GAME_UART_TX_PARITY_EN` defined: an even parity bit is inserted after d7. The frame is 11 bits (8E1).
- Not defined: no parity bit. The frame is 10 bits (8N1).
- The macro must match the receiver build.

## Structure

- Shared package `game_link_pkg`:
  - `MSG_START_BYTE = 8'hA5`
  - `MSG_SCORE_HDR = 8'h5C`
  - message-type enum (`MSG_NONE`, `MSG_START`, `MSG_SCORE`)
  - bit count per frame, derived from the parity macro
- Sub-module `uart_tx_byte`:
  - Byte serializer with `CLKS_PER_BIT` divider and bit counter.
  - Ports: `pclk`, `rst`, `data[7:0]`, `valid`, `ready`, `tx`, `done`.
  - The sequencer in `game_uart_tx` drives `valid` and `data`.

## Test plan

All scenarios use `CLKS_PER_BIT=4` and `MSG_GAP_BITS=1`.

- Reset, then no requests for 200 cycles → `tx`=1, `busy`=0, `msg_done` never pulses.
- `send_start` pulse → `tx` low 2 cycles later. Data bits sampled mid-bit read 1,0,1,0,0,1,0,1, then stop=1. `msg_done` pulses at cycle 42 after the request.
- `send_score` with `score`=37 → bytes `0x5C`, `0x25`, `0x79` back-to-back with no idle between stops and starts. `busy` stays high for the whole 120-cycle message.
- `send_start` and `send_score` (`score`=5) in the same cycle → START (`0xA5`), a 4-cycle idle gap, then `0x5C`, `0x05`, `0x59`.
- `send_score` with `score`=10 during an active START, then `send_score` with `score`=12 → a single SCORE message carrying 12, checksum `0x50`.
- Assert reset during byte 2 of a SCORE message → `tx`=1 in the same cycle (asynchronously). After release, `busy`=0 and no bytes are emitted.
- With `GAME_UART_TX_PARITY_EN` defined: START frame parity bit = 0, SCORE `score`=1 second-byte parity = 1. `msg_done` for START is at cycle 46.
